// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the memory access controller.
// Declares the controller state encoding, the default bus widths, the default
// ack timeout and the width of the wait counter.
package mem_ctrl_pkg;

    localparam int unsigned DATA_W_DEF  = 16;
    localparam int unsigned ADDR_W_DEF  = 16;
    localparam int unsigned TIMEOUT_DEF = 15;
    localparam int unsigned CNT_W       = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/access_timer.sv
// Wait-state counter used while a memory access is outstanding.
// Ports:
//   clk, rst : system clock; synchronous active-high reset
//   clr      : restart the count at 0 (held while no access is in flight)
//   en       : count one more cycle without an ack
//   expired  : registered flag, high while the count equals TIMEOUT-1
module access_timer
    import mem_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt;

    // expired is computed from the next count so it lines up with cnt
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt     <= '0;
            expired <= (LAST == '0);
        end else if (en) begin
            cnt     <= cnt + CNT_W'(1);
            expired <= ((cnt + CNT_W'(1)) == LAST);
        end
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// Memory access controller between the S-bus transfer gates and the M-bus.
// Holds MAR/MDR, runs single-word read/write handshakes with a wait-state
// memory, aborts after TIMEOUT strobe cycles without an ack.
// Ports:
//   clk, rst                : system clock; synchronous active-high reset
//   sma_en/sma_in           : load MAR (idle only)
//   smd_en/smd_in           : load MDR and clear m_bus_valid (idle only)
//   rd_req/wr_req           : one-cycle access requests
//   mem_addr/mem_wdata      : MAR / MDR towards memory
//   mem_re/mem_we           : strobes held until ack or timeout
//   mem_rdata/mem_ack       : memory response
//   m_bus_out/m_bus_valid   : MDR and read-data-valid towards the M-bus
//   busy/done/err           : status; done and err are one-cycle pulses
module mem_access_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int unsigned DATA_W  = DATA_W_DEF,
    parameter int unsigned ADDR_W  = ADDR_W_DEF,
    parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sma_en,
    input  logic [DATA_W-1:0] sma_in,
    input  logic              smd_en,
    input  logic [DATA_W-1:0] smd_in,
    input  logic              rd_req,
    input  logic              wr_req,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_re,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic [DATA_W-1:0] m_bus_out,
    output logic              m_bus_valid,
    output logic              busy,
    output logic              done,
    output logic              err
);

    state_t            state;
    logic [ADDR_W-1:0] mar;
    logic [DATA_W-1:0] mdr;
    logic              expired;
    logic              timer_clr_c;
    logic              timer_en_c;

    // Counter is held at 0 outside RD/WR so every access starts from 0
    assign timer_clr_c = (state != RD) && (state != WR);
    assign timer_en_c  = ((state == RD) || (state == WR)) && !mem_ack;

    access_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clr     (timer_clr_c),
        .en      (timer_en_c),
        .expired (expired)
    );

    assign mem_addr  = mar;
    assign mem_wdata = mdr;
    assign m_bus_out = mdr;

    // Controller FSM with MAR/MDR and registered status outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            mar         <= '0;
            mdr         <= '0;
            mem_re      <= 1'b0;
            mem_we      <= 1'b0;
            m_bus_valid <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    // Loads land on the same edge the strobe rises, so the
                    // access is issued with the freshly loaded MAR/MDR
                    if (sma_en) begin
                        mar <= ADDR_W'(sma_in);
                    end
                    if (smd_en) begin
                        mdr         <= smd_in;
                        m_bus_valid <= 1'b0;
                    end
                    if (rd_req && wr_req) begin
                        err <= 1'b1;
                    end else if (rd_req) begin
                        state  <= RD;
                        mem_re <= 1'b1;
                        busy   <= 1'b1;
                    end else if (wr_req) begin
                        state  <= WR;
                        mem_we <= 1'b1;
                        busy   <= 1'b1;
                    end
                end
                RD, WR: begin
                    // An ack in the last allowed cycle beats the timeout
                    if (mem_ack) begin
                        if (state == RD) begin
                            mdr         <= mem_rdata;
                            m_bus_valid <= 1'b1;
                        end
                        mem_re <= 1'b0;
                        mem_we <= 1'b0;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        state  <= DONE;
                    end else if (expired) begin
                        mem_re <= 1'b0;
                        mem_we <= 1'b0;
                        busy   <= 1'b0;
                        err    <= 1'b1;
                        state  <= IDLE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: transaction-level reference model
// plus a per-cycle compare process and a few literal pins.
module tb_mem_access_ctrl;

    localparam int unsigned DATA_W  = 16;
    localparam int unsigned ADDR_W  = 16;
    localparam int unsigned TIMEOUT = 15;

    logic              clk = 1'b0;
    logic              rst;
    logic              sma_en, smd_en, rd_req, wr_req, mem_ack;
    logic [DATA_W-1:0] sma_in, smd_in, mem_rdata;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata, m_bus_out;
    logic              mem_re, mem_we, m_bus_valid, busy, done, err;

    mem_access_ctrl #(
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .sma_en      (sma_en),
        .sma_in      (sma_in),
        .smd_en      (smd_en),
        .smd_in      (smd_in),
        .rd_req      (rd_req),
        .wr_req      (wr_req),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_re      (mem_re),
        .mem_we      (mem_we),
        .mem_rdata   (mem_rdata),
        .mem_ack     (mem_ack),
        .m_bus_out   (m_bus_out),
        .m_bus_valid (m_bus_valid),
        .busy        (busy),
        .done        (done),
        .err         (err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference state: architectural registers and expected status outputs
    logic [15:0] m_mar, m_mdr;
    logic        m_valid;
    logic        e_re, e_we, e_busy, e_done, e_err;
    bit          chk_en = 1'b0;

    // Running totals of output activity, sampled away from the active edge
    int n_re = 0, n_we = 0, n_done = 0, n_err = 0;
    int b_re, b_we, b_done, b_err;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("mem_addr",    32'(mem_addr),    32'(m_mar));
            check("mem_wdata",   32'(mem_wdata),   32'(m_mdr));
            check("m_bus_out",   32'(m_bus_out),   32'(m_mdr));
            check("m_bus_valid", 32'(m_bus_valid), 32'(m_valid));
            check("mem_re",      32'(mem_re),      32'(e_re));
            check("mem_we",      32'(mem_we),      32'(e_we));
            check("busy",        32'(busy),        32'(e_busy));
            check("done",        32'(done),        32'(e_done));
            check("err",         32'(err),         32'(e_err));
        end
    end

    always @(negedge clk) begin
        if (mem_re === 1'b1) n_re++;
        if (mem_we === 1'b1) n_we++;
        if (done === 1'b1)   n_done++;
        if (err === 1'b1)    n_err++;
    end

    task automatic snap();
        b_re = n_re; b_we = n_we; b_done = n_done; b_err = n_err;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        sma_en = 1'b0; smd_en = 1'b0; rd_req = 1'b0; wr_req = 1'b0; mem_ack = 1'b0;
    endtask

    // One idle cycle with optional MAR/MDR loads; a stray ack must be ignored
    task automatic idle_load(input bit la, input logic [15:0] a, input bit ld, input logic [15:0] d);
        idle_inputs();
        sma_en = la; sma_in = a; smd_en = ld; smd_in = d;
        mem_ack = 1'($urandom_range(0, 1));
        cyc();
        if (la) m_mar = a;
        if (ld) begin m_mdr = d; m_valid = 1'b0; end
        idle_inputs();
    endtask

    // kind: 0 read, 1 write, 2 both (conflict). Ack arrives in strobe cycle
    // index 'waits'; waits >= TIMEOUT means no ack at all.
    task automatic access(input int kind, input bit la, input logic [15:0] a,
                          input bit ld, input logic [15:0] d, input int waits,
                          input logic [15:0] rdata, input bit hostile);
        idle_inputs();
        sma_en = la; sma_in = a; smd_en = ld; smd_in = d;
        rd_req = (kind != 1); wr_req = (kind != 0);
        cyc();
        if (la) m_mar = a;
        if (ld) begin m_mdr = d; m_valid = 1'b0; end
        idle_inputs();
        if (kind == 2) begin
            e_err = 1'b1;
            cyc();
            e_err = 1'b0;
            return;
        end
        e_re = (kind == 0); e_we = (kind == 1); e_busy = 1'b1;
        for (int k = 0; k < int'(TIMEOUT); k++) begin
            sma_en = hostile ? 1'b1 : 1'($urandom_range(0, 1));
            sma_in = hostile ? 16'h9999 : 16'($urandom);
            smd_en = 1'($urandom_range(0, 1));
            smd_in = 16'($urandom);
            rd_req = 1'($urandom_range(0, 1));
            wr_req = 1'($urandom_range(0, 1));
            mem_rdata = rdata;
            mem_ack = (k == waits);
            cyc();
            if (k == waits) begin
                if (kind == 0) begin m_mdr = rdata; m_valid = 1'b1; end
                e_re = 1'b0; e_we = 1'b0; e_busy = 1'b0; e_done = 1'b1;
                break;
            end
            if (k == int'(TIMEOUT) - 1) begin
                e_re = 1'b0; e_we = 1'b0; e_busy = 1'b0; e_err = 1'b1;
            end
        end
        if (e_done) begin
            sma_en = 1'($urandom_range(0, 1)); sma_in = 16'($urandom);
            smd_en = 1'($urandom_range(0, 1)); smd_in = 16'($urandom);
            rd_req = hostile ? 1'b1 : 1'($urandom_range(0, 1));
            wr_req = hostile ? 1'b0 : 1'($urandom_range(0, 1));
            mem_ack = 1'($urandom_range(0, 1));
            cyc();
            e_done = 1'b0;
        end else begin
            idle_inputs();
            cyc();
            e_err = 1'b0;
        end
        idle_inputs();
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        sma_in = '0; smd_in = '0; mem_rdata = '0;
        m_mar = '0; m_mdr = '0; m_valid = 1'b0;
        e_re = 1'b0; e_we = 1'b0; e_busy = 1'b0; e_done = 1'b0; e_err = 1'b0;
        cyc();
        chk_en = 1'b1;
        cyc();
        rst = 1'b0;
        check("reset_addr", 32'(mem_addr), 32'h0);
        check("reset_busy", 32'(busy), 32'h0);

        // Idle loads
        idle_load(1'b1, 16'h1234, 1'b1, 16'hBEEF);
        check("load_addr",  32'(mem_addr),    32'h1234);
        check("load_wdata", 32'(mem_wdata),   32'hBEEF);
        check("load_valid", 32'(m_bus_valid), 32'h0);

        // Read with three wait cycles
        idle_load(1'b1, 16'h0040, 1'b0, 16'h0);
        snap();
        access(0, 1'b0, 16'h0, 1'b0, 16'h0, 3, 16'hABCD, 1'b0);
        check("rd3_re_cycles", 32'(n_re - b_re),     32'd4);
        check("rd3_done",      32'(n_done - b_done), 32'd1);
        check("rd3_mbus",      32'(m_bus_out),       32'hABCD);
        check("rd3_valid",     32'(m_bus_valid),     32'h1);
        idle_load(1'b0, 16'h0, 1'b1, 16'h5555);
        check("smd_clear_valid", 32'(m_bus_valid), 32'h0);
        check("smd_mbus",        32'(m_bus_out),   32'h5555);

        // Zero-wait write with loads in the request cycle
        snap();
        access(1, 1'b1, 16'h00F0, 1'b1, 16'hF0F0, 0, 16'h0, 1'b0);
        check("wr0_we_cycles", 32'(n_we - b_we),     32'd1);
        check("wr0_done",      32'(n_done - b_done), 32'd1);
        check("wr0_addr",      32'(mem_addr),        32'h00F0);

        // Timeout, then ack in the final allowed cycle
        snap();
        access(0, 1'b0, 16'h0, 1'b0, 16'h0, int'(TIMEOUT), 16'h1111, 1'b0);
        check("to_re_cycles", 32'(n_re - b_re),     32'd15);
        check("to_err",       32'(n_err - b_err),   32'd1);
        check("to_no_done",   32'(n_done - b_done), 32'd0);
        check("to_mdr_kept",  32'(m_bus_out),       32'hF0F0);
        snap();
        access(0, 1'b0, 16'h0, 1'b0, 16'h0, int'(TIMEOUT) - 1, 16'h2222, 1'b0);
        check("last_ack_done", 32'(n_done - b_done), 32'd1);
        check("last_ack_err",  32'(n_err - b_err),   32'd0);
        check("last_ack_mbus", 32'(m_bus_out),       32'h2222);

        // Conflicting requests
        snap();
        access(2, 1'b0, 16'h0, 1'b0, 16'h0, 0, 16'h0, 1'b0);
        check("conflict_err",    32'(n_err - b_err), 32'd1);
        check("conflict_strobe", 32'((n_re - b_re) + (n_we - b_we)), 32'd0);

        // Loads while busy and a request during DONE are dropped
        snap();
        access(0, 1'b1, 16'h0200, 1'b0, 16'h0, 2, 16'h1357, 1'b1);
        check("busy_sma_ignored", 32'(mem_addr),    32'h0200);
        check("done_req_ignored", 32'(n_re - b_re), 32'd3);

        // Reset on the second wait cycle of a write
        idle_load(1'b1, 16'h0100, 1'b1, 16'h7777);
        snap();
        idle_inputs(); wr_req = 1'b1;
        cyc();
        e_we = 1'b1; e_busy = 1'b1;
        idle_inputs();
        cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        m_mar = '0; m_mdr = '0; m_valid = 1'b0; e_we = 1'b0; e_busy = 1'b0;
        cyc();
        check("rst_mid_we",   32'(mem_we),          32'h0);
        check("rst_mid_addr", 32'(mem_addr),        32'h0);
        check("rst_mid_pulse", 32'((n_done - b_done) + (n_err - b_err)), 32'd0);

        // Randomized traffic against the model
        for (int i = 0; i < 250; i++) begin
            if ($urandom_range(0, 9) < 2) begin
                idle_load(1'($urandom_range(0, 1)), 16'($urandom),
                          1'($urandom_range(0, 1)), 16'($urandom));
            end else begin
                int kind;
                int waits;
                kind  = ($urandom_range(0, 7) == 0) ? 2 : int'($urandom_range(0, 1));
                waits = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, TIMEOUT + 2))
                                                    : int'($urandom_range(0, 3));
                access(kind, 1'($urandom_range(0, 1)), 16'($urandom),
                       1'($urandom_range(0, 1)), 16'($urandom), waits,
                       16'($urandom), 1'b0);
            end
        end

        cyc();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Memory access controller directly downstream of the S-bus transfer gates (SMA/SMD) and upstream of the M-bus gates (MMD/MIS).
- Holds the memory address register (MAR) and memory data register (MDR), loaded from the gated S-bus outputs.
- Runs single-word read/write handshakes with a wait-state memory and presents read data on the M-bus source with a valid flag.

Parameters:
- DATA_W, 16, data width of S-bus, M-bus and memory data.
- ADDR_W, 16, MAR/memory address width; MAR takes the low ADDR_W bits of sma_in.
- TIMEOUT, 15, maximum cycles an access waits for mem_ack before aborting; legal range 1..255.

Ports:
- clk  in  1  single system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- sma_en  in  1  load MAR from sma_in (gated SMA strobe).
- sma_in  in  DATA_W  SMA_out of the transfer gate.
- smd_en  in  1  load MDR from smd_in (gated SMD strobe).
- smd_in  in  DATA_W  SMD_out of the transfer gate.
- rd_req  in  1  start read at MAR, one-cycle pulse.
- wr_req  in  1  start write of MDR to MAR, one-cycle pulse.
- mem_addr  out  ADDR_W  memory address, always equal to MAR.
- mem_wdata  out  DATA_W  memory write data, always equal to MDR.
- mem_re  out  1  read strobe, held until ack or timeout.
- mem_we  out  1  write strobe, held until ack or timeout.
- mem_rdata  in  DATA_W  memory read data, sampled when mem_ack=1.
- mem_ack  in  1  memory completion, one cycle.
- m_bus_out  out  DATA_W  MDR contents, feeding the MMD/MIS gates.
- m_bus_valid  out  1  MDR holds data from a completed read.
- busy  out  1  access in progress (state RD or WR).
- done  out  1  one-cycle pulse when an access completes.
- err  out  1  one-cycle pulse on timeout or conflicting request.

Behaviour:
- Reset (sync, rst=1 at an edge):
  - State goes to IDLE.
  - MAR=0, MDR=0, timeout counter=0.
  - mem_re, mem_we, m_bus_valid, busy, done and err are all 0.
  - A reset mid-access drops mem_re/mem_we at that edge. No done or err pulse is produced, and MDR is cleared.
- All outputs are registered. mem_addr=MAR and mem_wdata=MDR.
- States: IDLE, RD, WR, DONE.
- IDLE:
  - sma_en=1 loads MAR at the next edge.
  - smd_en=1 loads MDR and clears m_bus_valid.
  - sma_en/smd_en in the same cycle as rd_req/wr_req load first. The access then uses the newly loaded values: the request is latched and issued next cycle with the updated MAR/MDR.
  - rd_req alone: go to RD, set mem_re=1 and busy=1 at the next edge.
  - wr_req alone: go to WR, set mem_we=1 and busy=1.
  - rd_req and wr_req together: no access, err=1 for one cycle, stay in IDLE.
- RD/WR:
  - The counter increments each cycle mem_ack=0.
  - mem_ack=1:
    - RD only: MDR<=mem_rdata and m_bus_valid<=1.
    - Strobe drops, go to DONE, done=1 in that DONE cycle.
  - Counter reaches TIMEOUT-1 with mem_ack=0:
    - Strobe drops, go to IDLE, err=1 for one cycle.
    - MDR, MAR and m_bus_valid are unchanged.
  - An ack in the final allowed cycle wins over the timeout.
- DONE: lasts one cycle, busy=0, then IDLE. Requests/loads in DONE are ignored.
- While busy or in DONE:
  - sma_en, smd_en, rd_req and wr_req are ignored and dropped, not queued.
  - A write completion leaves m_bus_valid unchanged.
- mem_ack in IDLE/DONE is ignored.
- Latency: request at edge n gives strobe high from n+1.
  - Zero-wait memory (ack in the first strobe cycle) gives done at n+2.
  - Each wait cycle adds one.
- Counter width is 8 bits. It resets to 0 on every entry to RD/WR.

Decomposition:
- Shared package (mem_ctrl_pkg):
  - state enum {IDLE, RD, WR, DONE}.
  - Default widths DATA_W/ADDR_W=16.
  - TIMEOUT default.
- Sub-module: access_timer, an 8-bit wait counter with clear, enable and expired (==TIMEOUT-1) output.
- The FSM and MAR/MDR stay in the top level.

Test Plan:
- Reset then idle: check outputs. sma_en=0x1234, smd_en=0xBEEF → mem_addr=0x1234, mem_wdata=0xBEEF, m_bus_valid=0, busy=0.
- Read, 3 wait cycles, MAR=0x0040, mem_rdata=0xABCD:
  - mem_re high 4 cycles.
  - done pulses once 1 cycle after ack.
  - m_bus_out=0xABCD, m_bus_valid=1.
  - A following smd_en=0x5555 clears valid and m_bus_out=0x5555.
- Write, zero-wait ack, MAR=0x00F0, MDR=0xF0F0:
  - mem_we high exactly 1 cycle, with mem_addr=0x00F0 and mem_wdata=0xF0F0.
  - done at req+2.
  - m_bus_valid unchanged.
- Timeout, TIMEOUT=15, read with no ack:
  - mem_re high exactly 15 cycles, then err pulse.
  - No done pulse, MDR unchanged.
  - A second run with ack in the 15th cycle completes with done and no err.
- Conflicts:
  - rd_req and wr_req together → err pulse, no strobe.
  - sma_en=0x9999 during busy → MAR unchanged.
  - rd_req during DONE → no new access.
- Reset mid-access: rst asserted on 2nd wait cycle of a write → mem_we=0 next edge, MAR=MDR=0, no done/err, IDLE.
